// File: rtl/srl_fifo_wide.sv
// Flow-controlled FIFO built on an addressable shift-register store, with a
// registered output stage and a registered programmable-full flag.
module srl_fifo_wide #(
  parameter int C_WIDTH      = 8,
  parameter int C_ADDR_WIDTH = 5,
  parameter int C_PROG_FULL  = 24
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [C_WIDTH-1:0]      s_payload,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [C_WIDTH-1:0]      m_payload,
  output logic [C_ADDR_WIDTH:0]   count,
  output logic                    prog_full
);

  localparam int unsigned DEPTH = 2 ** C_ADDR_WIDTH;

  localparam logic [C_ADDR_WIDTH-1:0] PTR_ZERO = '0;
  localparam logic [C_ADDR_WIDTH-1:0] PTR_MAX  = '1;
  localparam logic [C_ADDR_WIDTH-1:0] PTR_ONE  = C_ADDR_WIDTH'(1);
  localparam logic [C_ADDR_WIDTH:0]   CNT_ONE  = (C_ADDR_WIDTH + 1)'(1);
  localparam logic [C_ADDR_WIDTH:0]   PF_LEVEL = (C_ADDR_WIDTH + 1)'(C_PROG_FULL);

  // Shift-register store and its read pointer (address of the oldest word).
  logic [C_WIDTH-1:0]      srl_q [DEPTH];
  logic [C_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                    srl_empty_q, srl_empty_d;

  // Output stage and flow-control state.
  logic [C_WIDTH-1:0]      payload_q, payload_d;
  logic                    m_valid_q, m_valid_d;
  logic                    s_ready_q, s_ready_d;
  logic [C_ADDR_WIDTH:0]   count_q, count_d;
  logic                    prog_full_q, prog_full_d;

  logic push;
  logic pop;
  logic consume;
  logic srl_full_d;

  assign push    = s_valid & s_ready_q;
  assign pop     = ~srl_empty_q & (~m_valid_q | m_ready);
  assign consume = m_valid_q & m_ready;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    srl_empty_d = srl_empty_q;
    unique case ({push, pop})
      2'b10: begin
        if (srl_empty_q) srl_empty_d = 1'b0;
        else             rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end
      2'b01: begin
        if (rd_ptr_q == PTR_ZERO) srl_empty_d = 1'b1;
        else                      rd_ptr_d    = rd_ptr_q - PTR_ONE;
      end
      default: ;
    endcase

    // Ready is registered, so it must be derived from the post-edge fill level.
    srl_full_d = ~srl_empty_d & (rd_ptr_d == PTR_MAX);
    s_ready_d  = ~srl_full_d;
  end

  always_comb begin
    m_valid_d = m_valid_q;
    payload_d = payload_q;
    if (pop) begin
      m_valid_d = 1'b1;
      payload_d = srl_q[rd_ptr_q];
    end else if (consume) begin
      m_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, consume})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: ;
    endcase
    prog_full_d = (count_d >= PF_LEVEL);
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_ptr_q    <= '0;
      srl_empty_q <= 1'b1;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      count_q     <= '0;
      prog_full_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      srl_empty_q <= srl_empty_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= s_ready_d;
      count_q     <= count_d;
      prog_full_q <= prog_full_d;
    end
  end

  // NOTE: the store and the payload register carry no reset; their contents
  // are only ever observed behind the valid/empty flags, which are reset.
  always_ff @(posedge clk) begin
    payload_q <= payload_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      srl_q[0] <= s_payload;
      for (int i = 1; i < int'(DEPTH); i++) begin
        srl_q[i] <= srl_q[i-1];
      end
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_payload = payload_q;
  assign count     = count_q;
  assign prog_full = prog_full_q;

endmodule
